// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizes the serial line, oversamples it on i_Bclk ticks, deframes
// start/8 data/optional parity/stop, and holds the result in a read-handshake register.
module uart_rx_frame #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Pclk,
  input  logic       i_Reset_n,
  input  logic       i_Bclk,
  input  logic [1:0] i_Parity,
  input  logic       i_Rx_Serial,
  input  logic       i_Read,
  output logic [7:0] o_Data,
  output logic       o_Ready,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Reset is asserted asynchronously but released in step with i_Pclk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) rst_sync_q <= '0;
    else            rst_sync_q <= rst_sync_d;
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   line_prev_q, line_prev_d;
  logic                   line;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             par_mode_q, par_mode_d;
  logic                   perr_frame_q, perr_frame_d;
  logic [7:0]             data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   commit;

  assign line = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
    line_prev_d  = line;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_mode_d   = par_mode_q;
    perr_frame_d = perr_frame_q;
    data_d       = data_q;
    ready_d      = ready_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Arming on a 1->0 edge also keeps a held break from re-triggering.
        if (line_prev_q && !line) begin
          state_d      = S_START;
          cnt_d        = '0;
          par_mode_d   = i_Parity;
          perr_frame_d = 1'b0;
        end
      end
      S_START: begin
        if (i_Bclk) begin
          if (cnt_q == MID) begin
            cnt_d = '0;
            idx_d = '0;
            state_d = line ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (i_Bclk) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {line, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_d = (par_mode_q == 2'd1 || par_mode_q == 2'd2) ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_PARITY: begin
        if (i_Bclk) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (par_mode_q == 2'd1) perr_frame_d = (line != ^shift_q);
            else                    perr_frame_d = (line != ~^shift_q);
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_STOP: begin
        if (i_Bclk) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A commit takes priority over a coincident read.
    if (commit) begin
      data_d  = shift_q;
      perr_d  = perr_frame_q;
      ferr_d  = ~line;
      ready_d = 1'b1;
      ovr_d   = ready_q & ~i_Read;
    end else if (i_Read && ready_q) begin
      ready_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_Pclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sync_q       <= '1;
      line_prev_q  <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_mode_q   <= '0;
      perr_frame_q <= 1'b0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      line_prev_q  <= line_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_mode_q   <= par_mode_d;
      perr_frame_q <= perr_frame_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign o_Data       = data_q;
  assign o_Ready      = ready_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Overrun    = ovr_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_frame;

  localparam int OS   = 16;
  localparam int BDIV = 4;
  localparam int BITC = OS * BDIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bclk = 1'b0;
  logic [1:0] par = 2'd0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] o_Data;
  logic       o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy;

  int total = 0;
  int bad = 0;

  uart_rx_frame #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .i_Pclk(clk), .i_Reset_n(rst_n), .i_Bclk(bclk), .i_Parity(par),
    .i_Rx_Serial(rx), .i_Read(rd), .o_Data(o_Data), .o_Ready(o_Ready),
    .o_Parity_Err(o_Parity_Err), .o_Frame_Err(o_Frame_Err),
    .o_Overrun(o_Overrun), .o_Busy(o_Busy)
  );

  always #5 clk = ~clk;

  initial begin : bclk_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      bclk = (ph == 0);
      ph = (ph + 1) % BDIV;
    end
  end

  // Reference: parity bit a correct transmitter would send for this mode.
  function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] mode);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    if (mode == 2'd1) return logic'(ones % 2);
    return logic'((ones + 1) % 2);
  endfunction

  function automatic logic ref_perr(input logic [7:0] d, input logic [1:0] mode, input logic pbit);
    if (mode != 2'd1 && mode != 2'd2) return 1'b0;
    return pbit != ref_parity(d, mode);
  endfunction

  task automatic wait_bit();
    repeat (BITC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                            input logic stopb, input logic [1:0] mode_after);
    $display("frame data=%h mode=%0d pbit=%b stop=%b", d, mode, pbit, stopb);
    rx = 1'b0;
    par = mode;
    wait_bit();
    par = mode_after;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_bit();
    end
    if (mode == 2'd1 || mode == 2'd2) begin
      rx = pbit;
      wait_bit();
    end
    rx = stopb;
    wait_bit();
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({o_Data, o_Ready, o_Busy} !== 10'h0) begin
      bad++;
      $display("FAIL post_reset_idle: got %h want 0", {o_Data, o_Ready, o_Busy});
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    send_frame(8'h35, 2'd0, 1'b0, 1'b1, 2'd0);
    total++;
    if ({o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun} !== {8'h35, 4'b1000}) begin
      bad++;
      $display("FAIL basic_rx: got data=%h rdy/pe/fe/ov=%b%b%b%b want 35 1000", o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun);
    end
    do_read();
    total++;
    if (o_Ready !== 1'b0 || o_Data !== 8'h35) begin
      bad++;
      $display("FAIL basic_read: got rdy=%b data=%h want 0 35", o_Ready, o_Data);
    end
  endtask

  task automatic test_parity();
    logic [1:0] modes [3];
    logic       pbits [3];
    modes = '{2'd1, 2'd2, 2'd2};
    pbits = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h35, modes[i], pbits[i], 1'b1, 2'd0);
      total++;
      if (o_Data !== 8'h35 || o_Ready !== 1'b1 || o_Frame_Err !== 1'b0 ||
          o_Parity_Err !== ref_perr(8'h35, modes[i], pbits[i])) begin
        bad++;
        $display("FAIL parity_%0d: got data=%h rdy=%b pe=%b fe=%b want 35 1 %b 0", i, o_Data, o_Ready, o_Parity_Err, o_Frame_Err, ref_perr(8'h35, modes[i], pbits[i]));
      end
      do_read();
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 2'd0);
    total++;
    if (o_Data !== 8'hA5 || o_Frame_Err !== 1'b1 || o_Parity_Err !== 1'b0 || o_Ready !== 1'b1) begin
      bad++;
      $display("FAIL frame_err: got data=%h fe=%b pe=%b rdy=%b want a5 1 0 1", o_Data, o_Frame_Err, o_Parity_Err, o_Ready);
    end
    rx = 1'b1;
    wait_bit();
    do_read();
  endtask

  task automatic test_break();
    $display("break: line low 13 bit periods");
    rx = 1'b0;
    par = 2'd0;
    repeat (13) wait_bit();
    total++;
    if (o_Data !== 8'h00 || o_Frame_Err !== 1'b1 || o_Ready !== 1'b1 || o_Busy !== 1'b0) begin
      bad++;
      $display("FAIL break: got data=%h fe=%b rdy=%b busy=%b want 00 1 1 0", o_Data, o_Frame_Err, o_Ready, o_Busy);
    end
    rx = 1'b1;
    wait_bit();
    do_read();
    send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 2'd0);
    total++;
    if (o_Data !== 8'h5A || o_Frame_Err !== 1'b0 || o_Ready !== 1'b1) begin
      bad++;
      $display("FAIL after_break: got data=%h fe=%b rdy=%b want 5a 0 1", o_Data, o_Frame_Err, o_Ready);
    end
    do_read();
  endtask

  task automatic test_glitch();
    logic busy_seen;
    busy_seen = 1'b0;
    $display("glitch: 3-tick low pulse");
    rx = 1'b0;
    repeat (3 * BDIV) begin
      @(negedge clk);
      busy_seen |= o_Busy;
    end
    rx = 1'b1;
    repeat (80) begin
      @(negedge clk);
      busy_seen |= o_Busy;
    end
    total++;
    if (busy_seen !== 1'b1 || o_Busy !== 1'b0 || o_Ready !== 1'b0) begin
      bad++;
      $display("FAIL glitch: got busy_seen=%b busy=%b rdy=%b want 1 0 0", busy_seen, o_Busy, o_Ready);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 2'd0, 1'b0, 1'b1, 2'd0);
    send_frame(8'h22, 2'd0, 1'b0, 1'b1, 2'd0);
    total++;
    if (o_Data !== 8'h22 || o_Overrun !== 1'b1 || o_Ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overrun: got data=%h ov=%b rdy=%b want 22 1 1", o_Data, o_Overrun, o_Ready);
    end
    do_read();
    total++;
    if (o_Overrun !== 1'b0 || o_Ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_clear: got ov=%b rdy=%b want 0 0", o_Overrun, o_Ready);
    end
    send_frame(8'h11, 2'd0, 1'b0, 1'b1, 2'd0);
    fork
      send_frame(8'h22, 2'd0, 1'b0, 1'b1, 2'd0);
      begin : read_on_commit
        int guard;
        int n;
        guard = 0;
        n = 0;
        while (!o_Busy && guard < 400) begin
          @(negedge clk);
          guard++;
        end
        if (!o_Busy) begin
          total++;
          bad++;
          $display("FAIL b2b_busy_timeout: got busy=0 want 1 within 400 cycles");
        end else begin
          // Stop mid-sample is tick OS/2 + 9*OS after the frame goes busy.
          while (n < OS / 2 + 9 * OS - 1) begin
            @(posedge clk);
            if (bclk) n++;
          end
          repeat (BDIV) @(negedge clk);
          rd = 1'b1;
          @(negedge clk);
          rd = 1'b0;
        end
      end
    join
    total++;
    if (o_Data !== 8'h22 || o_Overrun !== 1'b0 || o_Ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_read_commit: got data=%h ov=%b rdy=%b want 22 0 1", o_Data, o_Overrun, o_Ready);
    end
  endtask

  task automatic test_reset_midframe();
    $display("reset during data bit 4 of ff");
    rx = 1'b0;
    par = 2'd0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_bit();
    end
    repeat (BITC / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_midframe: got %h want 0", {o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_bit();
    send_frame(8'h0F, 2'd0, 1'b0, 1'b1, 2'd0);
    total++;
    if ({o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun} !== {8'h0F, 4'b1000}) begin
      bad++;
      $display("FAIL after_reset_rx: got data=%h rdy/pe/fe/ov=%b%b%b%b want 0f 1000", o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, exp_data;
    logic [1:0] mode, mode_after;
    logic       pbit, stopb, exp_ready, exp_ovr, exp_perr, exp_ferr;
    do_read();
    exp_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      d          = 8'($urandom);
      mode       = 2'($urandom_range(0, 3));
      mode_after = 2'($urandom);
      pbit       = ref_parity(d, mode) ^ ($urandom_range(0, 3) == 0);
      stopb      = ($urandom_range(0, 4) != 0);
      send_frame(d, mode, pbit, stopb, mode_after);
      exp_ovr   = exp_ready;
      exp_ready = 1'b1;
      exp_data  = d;
      exp_perr  = ref_perr(d, mode, pbit);
      exp_ferr  = ~stopb;
      rx = 1'b1;
      wait_bit();
      total++;
      if ({o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun} !==
          {exp_data, exp_ready, exp_perr, exp_ferr, exp_ovr}) begin
        bad++;
        $display("FAIL rand_%0d: got data=%h rdy/pe/fe/ov=%b%b%b%b want %h %b%b%b%b", t, o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, exp_data, exp_ready, exp_perr, exp_ferr, exp_ovr);
      end
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        exp_ready = 1'b0;
        total++;
        if ({o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun} !== {exp_data, 4'b0000}) begin
          bad++;
          $display("FAIL rand_read_%0d: got data=%h rdy/pe/fe/ov=%b%b%b%b want %h 0000", t, o_Data, o_Ready, o_Parity_Err, o_Frame_Err, o_Overrun, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
